// File: rtl/junction_pkg.sv
// Shared lamp encodings, phase codes and lamp decode for the junction sequencer.
package junction_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5,
    WALK = 3'd6
  } phase_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  // Any unlisted code (including the illegal one) shows all-red.
  function automatic lamps_t decode_lamps(input phase_t p);
    lamps_t l;
    l.ns   = LAMP_RED;
    l.ew   = LAMP_RED;
    l.walk = 1'b0;
    case (p)
      NS_G:    l.ns = LAMP_GREEN;
      NS_Y:    l.ns = LAMP_YELLOW;
      EW_G:    l.ew = LAMP_GREEN;
      EW_Y:    l.ew = LAMP_YELLOW;
      WALK:    l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-phase dwell down-counter; expire flags the tick that ends the phase.
module dwell_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             hold,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && !hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_W'(RST_VAL);
    else        cnt_q <= cnt_d;
  end

  assign expire = tick && !hold && (cnt_q == '0);

endmodule

// File: rtl/junction_sequencer.sv
// Two-road junction phase sequencer with latched pedestrian walk and emergency all-red.
module junction_sequencer
  import junction_pkg::*;
#(
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned WALK_T   = 10,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);

  phase_t           state_q, state_d;
  logic             ped_pend_q, ped_pend_d;
  lamps_t           lamps_q, lamps_d;
  logic [2:0]       phase_q, phase_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             hold;
  logic             expire;

  dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_T - 1)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .hold     (hold),
    .expire   (expire)
  );

  // Next-phase selection; every transition reloads the dwell of the phase entered.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    hold     = 1'b0;
    case (state_q)
      NS_G: begin
        if (emerg || expire) begin
          state_d = NS_Y; load = 1'b1; load_val = YELLOW_LD;
        end
      end
      NS_Y: begin
        if (expire) begin
          state_d = AR_A; load = 1'b1; load_val = ALLRED_LD;
        end
      end
      AR_A: begin
        hold = emerg;
        if (expire) begin
          state_d = EW_G; load = 1'b1; load_val = GREEN_LD;
        end
      end
      EW_G: begin
        if (emerg || expire) begin
          state_d = EW_Y; load = 1'b1; load_val = YELLOW_LD;
        end
      end
      EW_Y: begin
        if (expire) begin
          state_d = AR_B; load = 1'b1; load_val = ALLRED_LD;
        end
      end
      AR_B: begin
        // Holding under emerg suppresses expire, so emerg outranks ped_pend here.
        hold = emerg;
        if (expire) begin
          load = 1'b1;
          if (ped_pend_q) begin
            state_d = WALK; load_val = WALK_LD;
          end else begin
            state_d = NS_G; load_val = GREEN_LD;
          end
        end
      end
      WALK: begin
        if (emerg) begin
          state_d = AR_B; load = 1'b1; load_val = ALLRED_LD;
        end else if (expire) begin
          state_d = NS_G; load = 1'b1; load_val = GREEN_LD;
        end
      end
      default: begin
        state_d = AR_B; load = 1'b1; load_val = ALLRED_LD;
      end
    endcase
  end

  // Walk request latch: clearing on WALK entry beats a same-cycle set.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (ped_req && (state_q != WALK)) ped_pend_d = 1'b1;
    if ((state_d == WALK) && (state_q != WALK)) ped_pend_d = 1'b0;
  end

  always_comb begin
    lamps_d = decode_lamps(state_d);
    phase_d = 3'(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AR_B;
      ped_pend_q <= 1'b0;
      lamps_q    <= '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
      phase_q    <= 3'(AR_B);
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      lamps_q    <= lamps_d;
      phase_q    <= phase_d;
    end
  end

  assign ns_light = lamps_q.ns;
  assign ew_light = lamps_q.ew;
  assign walk     = lamps_q.walk;
  assign phase    = phase_q;

endmodule

// File: doc/junction_sequencer.md
# junction_sequencer

Two-road intersection controller that sequences the one-hot RED/GREEN/YELLOW lamp heads of a north-south and an east-west approach through a fixed, safe phase cycle. Each phase lasts a programmable number of timebase ticks. The block adds a latched pedestrian-walk phase and an emergency override that forces all-red. It sits above the lamp outputs and is the only driver of both lamp heads and the walk signal.

## Interface
- GREEN_T, 20, green dwell in ticks (1..2^CNT_W-1)
- YELLOW_T, 4, yellow dwell in ticks (1..2^CNT_W-1)
- ALLRED_T, 2, all-red clearance dwell in ticks (1..2^CNT_W-1)
- WALK_T, 10, pedestrian walk dwell in ticks (1..2^CNT_W-1)
- CNT_W, 8, dwell counter width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timebase strobe; dwell counts only on cycles where tick=1
- ped_req  in  1  pedestrian button, already synchronous to clk, level or pulse
- emerg  in  1  emergency override, already synchronous to clk, level
- ns_light  out  3  NS lamp head: RED=3'b100, GREEN=3'b010, YELLOW=3'b001
- ew_light  out  3  EW lamp head, same encoding
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state code, for debug

## Operation
- State codes: NS_G=0, NS_Y=1, AR_A=2, EW_G=3, EW_Y=4, AR_B=5, WALK=6. Code 7 is illegal and recovers to AR_B.
- Normal cycle: NS_G → NS_Y → AR_A → EW_G → EW_Y → AR_B → NS_G.
- At the exit of AR_B, if ped_pend=1 the next state is WALK; WALK → NS_G.
- Lamp decode:
  - NS_G: ns=GREEN, ew=RED.
  - NS_Y: ns=YELLOW, ew=RED.
  - EW_G: ns=RED, ew=GREEN.
  - EW_Y: ns=RED, ew=YELLOW.
  - AR_A, AR_B, WALK: both heads RED.
  - walk=1 only in WALK.
  - Both heads are never non-RED at the same time in any state.
- Dwell counter: loaded with (dwell−1) on state entry. It decrements on each tick. When tick=1 and the count is 0, the state advances. Each state therefore lasts exactly its dwell value in ticks.
- ped_pend:
  - Set on any cycle with ped_req=1 while state≠WALK.
  - Cleared on entry to WALK.
  - ped_req during WALK is ignored.
  - A set and a WALK entry on the same cycle: the clear wins.
- emerg=1:
  - In NS_G or EW_G: the next edge goes to the matching yellow, with a fresh YELLOW_T load.
  - In WALK: the next edge goes to AR_B with a fresh ALLRED_T load; walk drops.
  - Yellow states run to completion normally.
  - In AR_A/AR_B: the counter freezes and the state holds while emerg=1. When emerg drops, the remaining count resumes.
  - emerg has priority over ped_pend at the AR_B exit; ped_pend is retained.

## Timing
- Reset values:
  - state=AR_B, counter=ALLRED_T−1, ped_pend=0.
  - ns_light=ew_light=3'b100, walk=0, phase=5.
  - Reset takes effect immediately on rst_n fall (asynchronous), mid-phase included.
- All outputs are registered or decoded from the state register only. Lamp changes coincide with the clk edge of the state change. No combinational path from any input to any output.
- Emergency response latency: 1 clk edge from emerg=1 to leaving green or walk.
- Period with tick=1 every cycle and no pedestrian request: 2·GREEN_T + 2·YELLOW_T + 2·ALLRED_T cycles.

## Structure
- Package junction_pkg holds:
  - Lamp constants LAMP_RED/LAMP_GREEN/LAMP_YELLOW.
  - The phase_t state enum with the codes above.
- Sub-module dwell_timer (CNT_W): ports load, load_val, tick, hold, expire. Instantiated once.
- The top module holds the FSM, the ped_pend latch and the output decode.

## Test plan
All scenarios use GREEN_T=3, YELLOW_T=2, ALLRED_T=1, WALK_T=2 and tick=1 unless stated otherwise.
- Reset release: phase sequence 5,0,0,0,1,1,2,3,3,3,4,4,5 repeating (period 12). Lamp heads match the decode every cycle, and both heads are never non-RED together.
- ped_req pulsed for 1 cycle during EW_G → after AR_B, WALK for 2 cycles with walk=1 and both heads 100, then NS_G. The following cycle has no WALK.
- emerg raised in the 1st NS_G cycle and held 10 cycles → NS_Y next edge, 2 cycles; AR_A holds until emerg drops; EW_G 1 cycle later.
- tick asserted every 4th cycle → NS_G lasts 12 clk cycles and NS_Y lasts 8.
- rst_n pulsed low mid-WALK → both heads 100, walk=0, phase=5 immediately, with no clk edge needed. ped_pend=0 after release.
- ped_req held high through WALK → exactly one WALK per request window. A ped_req arriving in the same cycle as the AR_B expiry is still honoured, because it is latched the following cycle and gets WALK on the next AR_B exit.
